// File: rtl/simd_pkg.sv
// Shared opcode encodings, sequencer state type and opcode classifiers for the SIMD issue path.
package simd_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_MAC   = 4'h3;
    localparam logic [3:0] OP_SHIFT = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_XOR   = 4'hA;
    localparam logic [3:0] OP_NOT   = 4'hB;
    localparam logic [3:0] OP_NOP   = 4'hF;

    localparam logic [11:0] NOP_INSTR = 12'hF00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CAPT,
        ST_HOLD
    } state_e;

    // Opcodes that are sent to the datapath and produce a result.
    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_SHIFT,
            OP_AND, OP_OR, OP_XOR, OP_NOT: is_legal = 1'b1;
            default:                       is_legal = 1'b0;
        endcase
    endfunction

    // Opcodes that need the longer multiplier latency.
    function automatic logic is_mul(input logic [3:0] op);
        is_mul = (op == OP_MUL) || (op == OP_MAC);
    endfunction

endpackage

// File: rtl/simd_instr_fifo.sv
// Instruction FIFO: DEPTH x WIDTH, count-based full/empty, flush empties it and drops a same-cycle push.
module simd_instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign pop_data = mem_q[rd_ptr_q];

    // Next pointer/count/storage values; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count_q, so it is not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/simd_issue_ctrl.sv
// Issue sequencer: buffers instructions, drives one op at a time to the SIMD datapath, captures its result.
module simd_issue_ctrl
    import simd_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [11:0] issue_instr,
    input  logic [31:0] simd_result,
    output logic [31:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic        err_illegal,
    output logic [15:0] op_count
);

    localparam int unsigned MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    state_e        state_q, state_d;
    logic [11:0]   instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;
    logic [15:0]   op_count_q, op_count_d;

    logic          fifo_pop;
    logic [11:0]   fifo_rd;
    logic          fifo_empty;
    logic          fifo_full;
    logic [3:0]    head_op;

    simd_instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (12)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (in_valid && !fifo_full),
        .push_data (in_instr),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign head_op     = fifo_rd[11:8];
    assign in_ready    = !fifo_full;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    assign err_illegal = err_q;
    assign op_count    = op_count_q;

    // Sequencer next-state, datapath drive and result capture; flush overrides everything but reset.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        op_count_d  = op_count_q;
        fifo_pop    = 1'b0;
        issue_instr = NOP_INSTR;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    instr_d  = fifo_rd;
                    if (is_legal(head_op)) begin
                        state_d = ST_EXEC;
                        cnt_d   = is_mul(head_op) ? CW'(MUL_LAT - 1) : CW'(ALU_LAT - 1);
                    end else if (head_op != OP_NOP) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                issue_instr = instr_q;
                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPT: begin
                res_data_d  = simd_result;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The head entry is discarded by the flush, so any decode of it is undone here.
        if (flush) begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
            op_count_d  = op_count_q;
            err_d       = err_q;
            fifo_pop    = 1'b0;
            issue_instr = NOP_INSTR;
        end
    end

    // Sequencer state and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= NOP_INSTR;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            op_count_q  <= op_count_d;
        end
    end

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Directed bench for simd_issue_ctrl with a registered behavioural datapath stub.
module tb_simd_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] in_instr = 12'h000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [11:0] issue_instr;
    logic [31:0] simd_result = 32'h0;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        err_illegal;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    simd_issue_ctrl #(
        .DEPTH   (4),
        .ALU_LAT (1),
        .MUL_LAT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_instr    (in_instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .issue_instr (issue_instr),
        .simd_result (simd_result),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .err_illegal (err_illegal),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stub_f(input logic [11:0] instr);
        case (instr)
            12'hF00: stub_f = 32'hFFFF_FFFF;
            12'h064: stub_f = 32'h0000_FFD1;
            12'h274: stub_f = 32'hF9E8_DB7C;
            default: stub_f = {20'hABCDE, instr};
        endcase
    endfunction

    // Datapath stub: result registered one cycle after the instruction it is computed from.
    always_ff @(posedge clk) begin
        simd_result <= stub_f(issue_instr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        assert (res_valid === 1'b1)
        else begin
            n_fail++;
            $error("FAIL %s: res_valid observed=%0b expected=1 within 20 cycles", tag, res_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_issue", 32'(issue_instr), 32'hF00);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err_illegal), 32'h0);
        check("rst_op_count", 32'(op_count), 32'h0);

        // 1. Single add, res_ready high
        res_ready = 1'b1;
        in_instr  = 12'h064;
        in_valid  = 1'b1;
        step();                                   // accept
        in_valid = 1'b0;
        check("t1_busy_queued", 32'(busy), 32'h1);
        step();                                   // pop -> EXEC
        check("t1_issue_exec", 32'(issue_instr), 32'h064);
        step();                                   // CAPT
        check("t1_issue_capt", 32'(issue_instr), 32'hF00);
        check("t1_valid_early", 32'(res_valid), 32'h0);
        step();                                   // HOLD
        check("t1_valid", 32'(res_valid), 32'h1);
        check("t1_data", res_data, 32'h0000_FFD1);
        step();                                   // consumed
        check("t1_valid_clr", 32'(res_valid), 32'h0);
        check("t1_op_count", 32'(op_count), 32'h1);
        check("t1_busy_idle", 32'(busy), 32'h0);

        // 2. mul holds the instruction for two cycles
        in_instr = 12'h274;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("t2_issue_c1", 32'(issue_instr), 32'h274);
        step();
        check("t2_issue_c2", 32'(issue_instr), 32'h274);
        step();
        check("t2_issue_capt", 32'(issue_instr), 32'hF00);
        check("t2_valid_early", 32'(res_valid), 32'h0);
        step();
        check("t2_valid", 32'(res_valid), 32'h1);
        check("t2_data", res_data, 32'hF9E8_DB7C);
        step();
        check("t2_op_count", 32'(op_count), 32'h2);

        // 3. Five ops with consumer stalled: four queued plus one in flight
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 12'h001; step();
        in_instr  = 12'h002; step();
        in_instr  = 12'h003; step();
        in_instr  = 12'h004; step();
        check("t3_in_ready_3q", 32'(in_ready), 32'h1);
        in_instr  = 12'h005; step();
        in_valid  = 1'b0;
        check("t3_in_ready_full", 32'(in_ready), 32'h0);
        check("t3_valid", 32'(res_valid), 32'h1);
        check("t3_data1", res_data, 32'hABCD_E001);
        step(); step(); step();
        check("t3_valid_held", 32'(res_valid), 32'h1);
        check("t3_data_held", res_data, 32'hABCD_E001);
        check("t3_still_full", 32'(in_ready), 32'h0);
        res_ready = 1'b1;
        step();
        wait_valid("t3_wait2");
        check("t3_data2", res_data, 32'hABCD_E002);
        step();
        wait_valid("t3_wait3");
        check("t3_data3", res_data, 32'hABCD_E003);
        step();
        wait_valid("t3_wait4");
        check("t3_data4", res_data, 32'hABCD_E004);
        step();
        wait_valid("t3_wait5");
        check("t3_data5", res_data, 32'hABCD_E005);
        step();
        check("t3_op_count", 32'(op_count), 32'h7);

        // 4. Reserved, NOP, then add
        in_valid = 1'b1;
        in_instr = 12'h700; step();
        check("t4_err_before_pop", 32'(err_illegal), 32'h0);
        in_instr = 12'hF00; step();
        check("t4_err_after_pop", 32'(err_illegal), 32'h1);
        check("t4_no_issue_reserved", 32'(issue_instr), 32'hF00);
        in_instr = 12'h011; step();
        in_valid = 1'b0;
        check("t4_no_issue_nop", 32'(issue_instr), 32'hF00);
        wait_valid("t4_wait_add");
        check("t4_data", res_data, 32'hABCD_E011);
        step();
        step(); step(); step();
        check("t4_op_count", 32'(op_count), 32'h8);
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_err_sticky", 32'(err_illegal), 32'h1);

        // 5. Flush during mac EXEC with two queued; same-cycle push dropped
        in_valid = 1'b1;
        in_instr = 12'h3E4; step();
        in_instr = 12'h021; step();
        in_instr = 12'h022; step();
        check("t5_issue_mac", 32'(issue_instr), 32'h3E4);
        flush    = 1'b1;
        in_instr = 12'h023;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5_issue_nop", 32'(issue_instr), 32'hF00);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_valid", 32'(res_valid), 32'h0);
        check("t5_in_ready", 32'(in_ready), 32'h1);
        step(); step(); step(); step(); step(); step();
        check("t5_valid_later", 32'(res_valid), 32'h0);
        check("t5_busy_later", 32'(busy), 32'h0);
        check("t5_op_count", 32'(op_count), 32'h8);

        // 6. Reset while holding a result
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 12'h031;
        step();
        in_valid  = 1'b0;
        wait_valid("t6_wait");
        check("t6_data", res_data, 32'hABCD_E031);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 32'(res_valid), 32'h0);
        check("t6_op_count", 32'(op_count), 32'h0);
        check("t6_err", 32'(err_illegal), 32'h0);
        check("t6_in_ready", 32'(in_ready), 32'h1);
        check("t6_issue", 32'(issue_instr), 32'hF00);
        check("t6_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
